// File: rtl/card_click_locator_pkg.sv
// Shared definitions for the card click locator: card-state encoding,
// board geometry constants and the locator FSM state type.
package card_click_locator_pkg;

  localparam int GRID_COLS   = 4;
  localparam int GRID_ROWS   = 4;
  localparam int NUM_CARDS   = GRID_COLS * GRID_ROWS;
  localparam int CARD_ADDR_W = 4;
  localparam int COORD_W     = 12;

  // Card state as stored in the game register file (2'b11 is reserved).
  typedef enum logic [1:0] {
    CARD_HIDDEN   = 2'b00,
    CARD_REVEALED = 2'b01,
    CARD_MATCHED  = 2'b10
  } card_state_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCATE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_CHECK  = 2'd3
  } loc_state_e;

  // Encode a 4-bit hit vector to a 2-bit position. Pitches exceed card sizes,
  // so at most one bit is ever set; the lowest set bit wins regardless.
  function automatic logic [1:0] enc4(input logic [3:0] onehot);
    enc4 = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (onehot[i]) enc4 = 2'(i);
    end
  endfunction

endpackage

// File: rtl/card_click_locator_if.sv
// Mouse/regfile/game-FSM signal bundle for the card click locator.
interface card_click_locator_if;
  import card_click_locator_pkg::*;

  logic                   enable;
  logic                   kind_of_event;
  logic [COORD_W-1:0]     mouse_xpos;
  logic [COORD_W-1:0]     mouse_ypos;
  logic [1:0]             card_test_state;
  logic [CARD_ADDR_W-1:0] card_to_test_address;
  logic [CARD_ADDR_W-1:0] card_clicked_address;
  logic                   event_occurred;

  // Locator side.
  modport slave (
    input  enable, kind_of_event, mouse_xpos, mouse_ypos, card_test_state,
    output card_to_test_address, card_clicked_address, event_occurred
  );

  // Environment side (mouse, register file, game state machine).
  modport master (
    output enable, kind_of_event, mouse_xpos, mouse_ypos, card_test_state,
    input  card_to_test_address, card_clicked_address, event_occurred
  );

endinterface

// File: rtl/card_click_locator_pipe_delay.sv
// Register chain of CLK_DEL stages, each resetting to zero.
// CLK_DEL = 0 degenerates to a wire.
module pipe_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (CLK_DEL == 0) begin : g_pass
    assign dout = din;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [CLK_DEL];

    // Shift din through the chain one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < CLK_DEL; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < CLK_DEL; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[CLK_DEL-1];
  end

endmodule

// File: rtl/card_click_locator.sv
// Card click locator: turns a left-button click into a validated selection
// on the 4x4 board. Click edge -> grid hit test -> regfile read -> pulse if
// the card is still face-down.
module card_click_locator
  import card_click_locator_pkg::*;
#(
  parameter int X_OFFSET     = 32,
  parameter int Y_OFFSET     = 32,
  parameter int CARD_W       = 200,
  parameter int CARD_H       = 150,
  parameter int X_PITCH      = 256,
  parameter int Y_PITCH      = 184,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  card_click_locator_if.slave  bus
);

  // Tag on the read-valid flag so a flag still in flight from an aborted
  // operation cannot be mistaken for the current one. 16 tags cover any
  // READ_LATENCY below 32 at the fastest possible restart rate.
  localparam int TAG_W = 4;

  loc_state_e             state_q;
  logic                   kind_q;
  logic [COORD_W-1:0]     x_q;
  logic [COORD_W-1:0]     y_q;
  logic [CARD_ADDR_W-1:0] test_addr_q;
  logic [CARD_ADDR_W-1:0] clicked_addr_q;
  logic                   event_q;
  logic [TAG_W-1:0]       tag_q;

  logic                   click;
  logic                   issue;
  logic                   hit;
  logic                   rd_ready;
  logic [TAG_W-1:0]       tag_d;
  logic [GRID_COLS-1:0]   col_hit;
  logic [GRID_ROWS-1:0]   row_hit;
  logic [CARD_ADDR_W-1:0] hit_idx;
  logic [TAG_W:0]         dly_din;
  logic [TAG_W:0]         dly_dout;

  // Per-column / per-row range tests; right and bottom edges are exclusive.
  for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
    localparam int XLO = X_OFFSET + c * X_PITCH;
    assign col_hit[c] = (32'(x_q) >= 32'(XLO)) && (32'(x_q) < 32'(XLO + CARD_W));
  end

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    localparam int YLO = Y_OFFSET + r * Y_PITCH;
    assign row_hit[r] = (32'(y_q) >= 32'(YLO)) && (32'(y_q) < 32'(YLO + CARD_H));
  end

  assign hit     = (|col_hit) && (|row_hit);
  assign hit_idx = {enc4(row_hit), enc4(col_hit)};

  assign click    = (state_q == ST_IDLE) && bus.enable && bus.kind_of_event && !kind_q;
  assign issue    = (state_q == ST_LOCATE) && bus.enable && hit;
  assign tag_d    = tag_q + TAG_W'(1);
  assign dly_din  = {issue, tag_d};
  assign rd_ready = dly_dout[TAG_W] && (dly_dout[TAG_W-1:0] == tag_q);

  pipe_delay #(
    .WIDTH   (TAG_W + 1),
    .CLK_DEL (READ_LATENCY)
  ) u_rd_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_din),
    .dout (dly_dout)
  );

  // Button level history, tracked regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) kind_q <= 1'b0;
    else     kind_q <= bus.kind_of_event;
  end

  // Capture the cursor position at the click edge.
  always_ff @(posedge clk) begin
    if (click) begin
      x_q <= bus.mouse_xpos;
      y_q <= bus.mouse_ypos;
    end
  end

  // Locator FSM with registered outputs; dropping enable aborts silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      test_addr_q    <= '0;
      clicked_addr_q <= '0;
      event_q        <= 1'b0;
      tag_q          <= '0;
    end else begin
      event_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (click) state_q <= ST_LOCATE;
          end
          ST_LOCATE: begin
            if (hit) begin
              test_addr_q <= hit_idx;
              tag_q       <= tag_d;
              state_q     <= (READ_LATENCY == 0) ? ST_CHECK : ST_WAIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (rd_ready) state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            if (bus.card_test_state == CARD_HIDDEN) begin
              clicked_addr_q <= test_addr_q;
              event_q        <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.card_to_test_address = test_addr_q;
  assign bus.card_clicked_address = clicked_addr_q;
  assign bus.event_occurred       = event_q;

endmodule

// File: tb/tb_card_click_locator.sv
// Scoreboard bench for card_click_locator with a registered-read regfile model.
module tb_card_click_locator;

  localparam int XO = 32, YO = 32, CW = 200, CH = 150, XP = 256, YP = 184;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic [1:0] mem [16];
  logic [1:0] rd_q;

  card_click_locator_if bus();

  card_click_locator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Register file with one cycle of read latency.
  always_ff @(posedge clk) rd_q <= mem[bus.card_to_test_address];
  assign bus.card_test_state = rd_q;

  // Reference hit test: which card (if any) contains the point.
  function automatic int locate(input int x, input int y);
    int dx, dy;
    dx = x - XO;
    dy = y - YO;
    if (dx < 0 || dy < 0) return -1;
    if (dx / XP > 3 || dx % XP >= CW) return -1;
    if (dy / YP > 3 || dy % YP >= CH) return -1;
    return (dy / YP) * 4 + dx / XP;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected acceptance.
  always @(negedge clk) begin
    if (!rst && bus.event_occurred) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: actual addr=%0d at cycle %0d, required no event",
                 bus.card_clicked_address, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.card_clicked_address != 4'(e.idx) || cyc != e.cyc) begin
          n_errors++;
          $display("FAIL event: actual addr=%0d cycle=%0d, required addr=%0d cycle=%0d",
                   bus.card_clicked_address, cyc, e.idx, e.cyc);
        end
      end
    end
  end

  // Click with the button held for 'hold' sampled edges; predicts the outcome.
  task automatic click(input int x, input int y, input int hold);
    int idx, e0;
    @(posedge clk); #2;
    bus.mouse_xpos    = 12'(x);
    bus.mouse_ypos    = 12'(y);
    bus.kind_of_event = 1'b1;
    @(posedge clk); #1;
    e0  = cyc;
    idx = locate(x, y);
    if (idx >= 0 && mem[idx] == 2'b00) exp_q.push_back('{idx, e0 + 3});
    #1;
    if (hold <= 1) bus.kind_of_event = 1'b0;
    @(posedge clk); #1;
    if (idx >= 0) chk("test_addr_at_E0+1", bus.card_to_test_address, idx);
    if (hold > 1) begin
      repeat (hold - 2) @(posedge clk);
      #1 bus.kind_of_event = 1'b0;
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    bus.enable        = 1'b0;
    bus.kind_of_event = 1'b0;
    bus.mouse_xpos    = '0;
    bus.mouse_ypos    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_test_addr", bus.card_to_test_address, 0);
    chk("reset_clicked_addr", bus.card_clicked_address, 0);
    chk("reset_event", bus.event_occurred, 0);
    #1 rst = 1'b0;
    @(posedge clk); #2 bus.enable = 1'b1;

    // Basic acceptance and state filtering.
    click(400, 300, 1);
    click(100, 100, 1);
    drained("hidden_cards_accepted");
    chk("clicked_addr_0", bus.card_clicked_address, 0);
    mem[0] = 2'b01;
    click(100, 100, 1);
    mem[0] = 2'b10;
    click(100, 100, 1);
    chk("clicked_addr_stays_0", bus.card_clicked_address, 0);
    mem[0] = 2'b00;

    // Gaps and outside the grid.
    click(250, 100, 1);
    click(100, 190, 1);
    click(1010, 700, 1);
    drained("misses_silent");

    // Edge boundaries.
    click(231, 181, 1);
    click(232, 100, 1);
    click(999, 733, 1);
    drained("edges");
    chk("clicked_addr_15", bus.card_clicked_address, 15);

    // Held button gives a single click.
    click(400, 300, 100);
    drained("held_button_one_event");

    // Button already high when enable rises.
    @(posedge clk); #2 bus.enable = 1'b0;
    bus.mouse_xpos = 12'd400; bus.mouse_ypos = 12'd300; bus.kind_of_event = 1'b1;
    repeat (3) @(posedge clk);
    #2 bus.enable = 1'b1;
    repeat (10) @(posedge clk);
    #2 bus.kind_of_event = 1'b0;
    repeat (6) @(posedge clk);
    drained("prehigh_no_event");

    // Enable dropped at E0+2.
    prev = 32'(bus.card_clicked_address);
    @(posedge clk); #2;
    bus.mouse_xpos = 12'd594; bus.mouse_ypos = 12'd300; bus.kind_of_event = 1'b1;
    @(posedge clk); #2 bus.kind_of_event = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 bus.enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("enable_drop_clicked_hold", bus.card_clicked_address, prev);
    chk("enable_drop_test_addr_hold", bus.card_to_test_address, 6);
    bus.enable = 1'b1;
    repeat (3) @(posedge clk);

    // Reset asserted at E0+1.
    @(posedge clk); #2;
    bus.mouse_xpos = 12'd400; bus.mouse_ypos = 12'd300; bus.kind_of_event = 1'b1;
    @(posedge clk); #2 bus.kind_of_event = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midop_reset_test_addr", bus.card_to_test_address, 0);
    chk("midop_reset_clicked_addr", bus.card_clicked_address, 0);
    chk("midop_reset_event", bus.event_occurred, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    drained("reset_abort_no_event");

    // Randomized clicks and card states.
    for (int n = 0; n < 60; n++) begin
      int x, y;
      for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        x = XO + $urandom_range(0, 3) * XP + $urandom_range(0, CW - 1);
        y = YO + $urandom_range(0, 3) * YP + $urandom_range(0, CH - 1);
      end else begin
        x = $urandom_range(0, 1100);
        y = $urandom_range(0, 800);
      end
      click(x, y, $urandom_range(1, 4));
    end
    drained("random_all_events_seen");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
